// File: rtl/memoria_ram.sv
// Unified instruction/data memory: byte array accessed as 32-bit big-endian words,
// any byte alignment, wrapping at the top of the array, registered read-before-write.
module memoria_ram #(
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_W      = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Address,
  input  logic              Wr,
  input  logic [31:0]       Datain,
  output logic [31:0]       Dataout
);

  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0]    mem [DEPTH_BYTES];
  logic [AW-1:0] ea0, ea1, ea2, ea3;

  // Byte indices are AW bits wide, so EA+i wraps to the bottom of the array by itself.
  assign ea0 = Address[AW-1:0];
  assign ea1 = ea0 + AW'(1);
  assign ea2 = ea0 + AW'(2);
  assign ea3 = ea0 + AW'(3);

  // Upper address bits alias onto the same bytes and are intentionally unused.
  generate
    if (ADDR_W > AW) begin : g_upper
      logic unused_upper;
      assign unused_upper = ^Address[ADDR_W-1:AW];
    end
  endgenerate

  // NOTE: the whole array is cleared by the asynchronous reset, so it maps to
  // flops rather than a RAM macro; macros cannot be reset in one step.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Dataout <= '0;
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments mean the read below samples the bytes as
      // they were before this edge's write, giving read-before-write for free.
      Dataout <= {mem[ea0], mem[ea1], mem[ea2], mem[ea3]};
      if (Wr) begin
        mem[ea0] <= Datain[31:24];
        mem[ea1] <= Datain[23:16];
        mem[ea2] <= Datain[15:8];
        mem[ea3] <= Datain[7:0];
      end
    end
  end

endmodule

// File: tb/tb_memoria_ram.sv
// Self-checking bench for memoria_ram: directed scenarios plus randomized traffic
// compared against a byte-array reference model.
module tb_memoria_ram;

  localparam int DEPTH = 256;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] Address = '0;
  logic        Wr = 1'b0;
  logic [31:0] Datain = '0;
  logic [31:0] Dataout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  byte unsigned ref_mem [DEPTH];

  memoria_ram #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Address(Address),
    .Wr     (Wr),
    .Datain (Datain),
    .Dataout(Dataout)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] model_read(logic [31:0] addr);
    int ea;
    ea = int'(addr % DEPTH);
    return {ref_mem[ea], ref_mem[(ea + 1) % DEPTH],
            ref_mem[(ea + 2) % DEPTH], ref_mem[(ea + 3) % DEPTH]};
  endfunction

  task automatic model_write(logic [31:0] addr, logic [31:0] data);
    int ea;
    ea = int'(addr % DEPTH);
    ref_mem[ea]               = data[31:24];
    ref_mem[(ea + 1) % DEPTH] = data[23:16];
    ref_mem[(ea + 2) % DEPTH] = data[15:8];
    ref_mem[(ea + 3) % DEPTH] = data[7:0];
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
  endtask

  // Drives one access, lets one rising edge pass and returns 1 time unit after it.
  // exp is the model's prediction of Dataout after that edge.
  task automatic cycle(input logic wr, input logic [31:0] addr, input logic [31:0] din,
                       output logic [31:0] exp);
    Wr = wr;
    Address = addr;
    Datain = din;
    exp = model_read(addr);
    if (wr) model_write(addr, din);
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    @(posedge Clock);
    #3;
    Reset = 1'b1;
    #1;
    model_clear();
    total_cnt++;
    if (Dataout !== 32'h0) $display("FAIL reset_immediate: got %h want %h", Dataout, 32'h0);
    else pass_cnt++;
    @(posedge Clock);
    #3;
    Reset = 1'b0;
    cycle(1'b0, 32'h10, 32'h0, exp);
    total_cnt++;
    if (Dataout !== 32'h0 || exp !== 32'h0)
      $display("FAIL reset_read_0x10: got %h want %h", Dataout, 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_aligned();
    logic [31:0] exp;
    logic [31:0] held;
    cycle(1'b1, 32'h04, 32'hDEADBEEF, exp);
    cycle(1'b0, 32'h04, 32'h0, exp);
    total_cnt++;
    if (Dataout !== 32'hDEADBEEF) $display("FAIL aligned_read: got %h want %h", Dataout, 32'hDEADBEEF);
    else pass_cnt++;
    // Address change mid-cycle must not reach Dataout before the next edge.
    held = Dataout;
    Address = 32'h05;
    #2;
    total_cnt++;
    if (Dataout !== 32'hDEADBEEF) $display("FAIL no_comb_path: got %h want %h", Dataout, 32'hDEADBEEF);
    else pass_cnt++;
    cycle(1'b0, 32'h05, 32'h0, exp);
    total_cnt++;
    if (Dataout !== 32'hADBEEF00 || exp !== 32'hADBEEF00)
      $display("FAIL unaligned_read: got %h want %h", Dataout, 32'hADBEEF00);
    else pass_cnt++;
    total_cnt++;
    if (held === Dataout) $display("FAIL read_update: got %h want %h", Dataout, 32'hADBEEF00);
    else pass_cnt++;
  endtask

  task automatic test_read_before_write();
    logic [31:0] exp;
    cycle(1'b1, 32'h08, 32'h11223344, exp);
    cycle(1'b1, 32'h08, 32'hCAFEBABE, exp);
    total_cnt++;
    if (Dataout !== 32'h11223344) $display("FAIL rbw_old: got %h want %h", Dataout, 32'h11223344);
    else pass_cnt++;
    cycle(1'b0, 32'h08, 32'h0, exp);
    total_cnt++;
    if (Dataout !== 32'hCAFEBABE) $display("FAIL rbw_new: got %h want %h", Dataout, 32'hCAFEBABE);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    cycle(1'b1, 32'hFE, 32'hA1B2C3D4, exp);
    cycle(1'b0, 32'h00, 32'h0, exp);
    total_cnt++;
    if (Dataout !== 32'hC3D40000) $display("FAIL wrap_low: got %h want %h", Dataout, 32'hC3D40000);
    else pass_cnt++;
    cycle(1'b0, 32'hFE, 32'h0, exp);
    total_cnt++;
    if (Dataout !== 32'hA1B2C3D4) $display("FAIL wrap_word: got %h want %h", Dataout, 32'hA1B2C3D4);
    else pass_cnt++;
    cycle(1'b0, 32'hFF, 32'h0, exp);
    total_cnt++;
    if (Dataout !== 32'hB2C3D400) $display("FAIL wrap_ff: got %h want %h", Dataout, 32'hB2C3D400);
    else pass_cnt++;
  endtask

  task automatic test_alias();
    logic [31:0] exp;
    cycle(1'b1, 32'h00000120, 32'h01020304, exp);
    cycle(1'b0, 32'h00000020, 32'h0, exp);
    total_cnt++;
    if (Dataout !== 32'h01020304) $display("FAIL alias_read: got %h want %h", Dataout, 32'h01020304);
    else pass_cnt++;
    cycle(1'b0, 32'hFFFFFF20, 32'h0, exp);
    total_cnt++;
    if (Dataout !== 32'h01020304) $display("FAIL alias_high: got %h want %h", Dataout, 32'h01020304);
    else pass_cnt++;
  endtask

  task automatic test_overlap();
    logic [31:0] exp;
    cycle(1'b1, 32'h40, 32'h11111111, exp);
    cycle(1'b1, 32'h41, 32'h22222222, exp);
    cycle(1'b0, 32'h40, 32'h0, exp);
    total_cnt++;
    if (Dataout !== 32'h11222222) $display("FAIL overlap: got %h want %h", Dataout, 32'h11222222);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    cycle(1'b1, 32'h30, 32'h55AA55AA, exp);
    cycle(1'b0, 32'h30, 32'h0, exp);
    total_cnt++;
    if (Dataout !== 32'h55AA55AA) $display("FAIL pre_reset_read: got %h want %h", Dataout, 32'h55AA55AA);
    else pass_cnt++;
    #2;
    Reset = 1'b1;
    #1;
    model_clear();
    total_cnt++;
    if (Dataout !== 32'h0) $display("FAIL reset_mid_immediate: got %h want %h", Dataout, 32'h0);
    else pass_cnt++;
    // A write attempted while reset is held must be ignored.
    Wr = 1'b1;
    Address = 32'h30;
    Datain = 32'hFFFFFFFF;
    @(posedge Clock);
    #1;
    total_cnt++;
    if (Dataout !== 32'h0) $display("FAIL reset_held: got %h want %h", Dataout, 32'h0);
    else pass_cnt++;
    #2;
    Reset = 1'b0;
    cycle(1'b0, 32'h30, 32'h0, exp);
    total_cnt++;
    if (Dataout !== 32'h0) $display("FAIL post_reset_read: got %h want %h", Dataout, 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] exp;
    logic [31:0] addr;
    for (int n = 0; n < 400; n++) begin
      addr = $urandom();
      // Concentrate on a small window so reads frequently hit written bytes.
      if ($urandom_range(3) != 0) addr = {addr[31:8], 2'b00, addr[5:0]} ^ 32'hC0;
      cycle(1'($urandom_range(1)), addr, $urandom(), exp);
      total_cnt++;
      if (Dataout !== exp) $display("FAIL random[%0d] addr=%h: got %h want %h", n, addr, Dataout, exp);
      else pass_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_aligned();
    test_read_before_write();
    test_wrap();
    test_alias();
    test_overlap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
